// File: rtl/iob_master_if.sv
// iob_master_if: posting-stage request handshake and I/O bus pins.
// master modport is the sequencer side; slave is the bus/posting side.
interface iob_master_if;
    logic IOREQ, IORW, IOL, IOU;
    logic nDTACK, nVPA, nBERR, E;
    logic IOACT, IOBERR;
    logic nASout, nLDSout, nUDSout, nVMAout;
    logic nWEout, nDoutOE, nDinLE;

    modport master (
        input  IOREQ, IORW, IOL, IOU,
        input  nDTACK, nVPA, nBERR, E,
        output IOACT, IOBERR,
        output nASout, nLDSout, nUDSout, nVMAout,
        output nWEout, nDoutOE, nDinLE
    );

    modport slave (
        output IOREQ, IORW, IOL, IOU,
        output nDTACK, nVPA, nBERR, E,
        input  IOACT, IOBERR,
        input  nASout, nLDSout, nUDSout, nVMAout,
        input  nWEout, nDoutOE, nDinLE
    );
endinterface

// File: rtl/iob_master.sv
// iob_master: 68000-style I/O bus cycle sequencer with 6800 VPA/VMA path.
// Define IOB_MASTER_TIMEOUT_EN to add the wait-state bus-error watchdog.
module iob_master #(
    parameter logic [9:0] TIMEOUT = 10'd1000
) (
    input  logic         CLK,
    input  logic         nRST,
    iob_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, S_ADDR, S_WAIT, S_VPA, S_VMA, S_END, S_REC
    } state_t;

    state_t state, state_d;

    logic [1:0] dt_q, vp_q, be_q, e_q;
    logic       DTs, VPs, BEs, Es;

    logic rw_q, l_q, u_q, err_q, ehi_q;
    logic rw_d, l_d, u_d, err_d, ehi_d;
    logic act_q, berr_q, as_q, lds_q, uds_q;
    logic act_d, berr_d, as_d, lds_d, uds_d;
    logic vma_q, we_q, doe_q, dle_q;
    logic vma_d, we_d, doe_d, dle_d;
    logic fin, fin_err, tmo;

`ifdef IOB_MASTER_TIMEOUT_EN
    logic [9:0] cnt_q, cnt_d;
    assign tmo = (cnt_q + 10'd1 == TIMEOUT);
`else
    assign tmo = 1'b0;
`endif

    // terminations held internally active-high; reset value is "negated"
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dt_q <= 2'b00;
            vp_q <= 2'b00;
            be_q <= 2'b00;
            e_q  <= 2'b00;
        end else begin
            dt_q <= {dt_q[0], ~bus.nDTACK};
            vp_q <= {vp_q[0], ~bus.nVPA};
            be_q <= {be_q[0], ~bus.nBERR};
            e_q  <= {e_q[0], bus.E};
        end
    end

    assign DTs = dt_q[1];
    assign VPs = vp_q[1];
    assign BEs = be_q[1];
    assign Es  = e_q[1];

    always_comb begin
        state_d = state;
        rw_d    = rw_q;
        l_d     = l_q;
        u_d     = u_q;
        err_d   = err_q;
        ehi_d   = ehi_q;
        act_d   = act_q;
        berr_d  = berr_q;
        as_d    = as_q;
        lds_d   = lds_q;
        uds_d   = uds_q;
        vma_d   = vma_q;
        we_d    = we_q;
        doe_d   = doe_q;
        dle_d   = dle_q;
        fin     = 1'b0;
        fin_err = 1'b0;
`ifdef IOB_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state)
            IDLE: begin
                if (bus.IOREQ) begin
                    state_d = S_ADDR;
                    rw_d    = bus.IORW;
                    l_d     = bus.IOL;
                    u_d     = bus.IOU;
                    err_d   = 1'b0;
                    act_d   = 1'b1;
                    berr_d  = 1'b0;
                end
            end
            S_ADDR: begin
                state_d = S_WAIT;
                we_d    = rw_q;
                doe_d   = rw_q;
                as_d    = 1'b0;
                if (rw_q) begin
                    lds_d = ~l_q;
                    uds_d = ~u_q;
                end
            end
            S_WAIT: begin
                // write data strobes trail nAS by one cycle
                if (!rw_q) begin
                    lds_d = ~l_q;
                    uds_d = ~u_q;
                end
                if (BEs) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (DTs) begin
                    fin = 1'b1;
                end else if (VPs) begin
                    state_d = S_VPA;
                end else if (tmo) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_VPA: begin
                ehi_d = 1'b0;
                if (BEs) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (!Es) begin
                    vma_d   = 1'b0;
                    state_d = S_VMA;
                end else if (tmo) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_VMA: begin
                // a full E high phase must pass before the falling edge ends it
                if (Es) ehi_d = 1'b1;
                if (BEs) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (ehi_q && !Es) begin
                    fin = 1'b1;
                end else if (tmo) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_END: begin
                state_d = S_REC;
                as_d    = 1'b1;
                lds_d   = 1'b1;
                uds_d   = 1'b1;
                vma_d   = 1'b1;
                doe_d   = 1'b1;
                dle_d   = 1'b1;
                act_d   = 1'b0;
                berr_d  = err_q;
            end
            S_REC: begin
                if (!(DTs || VPs || BEs)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef IOB_MASTER_TIMEOUT_EN
        if (state == IDLE)
            cnt_d = 10'd0;
        else if (state inside {S_WAIT, S_VPA, S_VMA})
            cnt_d = cnt_q + 10'd1;
`endif
        if (fin) begin
            state_d = S_END;
            err_d   = fin_err;
            dle_d   = ~(rw_q & ~fin_err);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            rw_q   <= 1'b0;
            l_q    <= 1'b0;
            u_q    <= 1'b0;
            err_q  <= 1'b0;
            ehi_q  <= 1'b0;
            act_q  <= 1'b0;
            berr_q <= 1'b0;
            as_q   <= 1'b1;
            lds_q  <= 1'b1;
            uds_q  <= 1'b1;
            vma_q  <= 1'b1;
            we_q   <= 1'b1;
            doe_q  <= 1'b1;
            dle_q  <= 1'b1;
`ifdef IOB_MASTER_TIMEOUT_EN
            cnt_q  <= 10'd0;
`endif
        end else begin
            state  <= state_d;
            rw_q   <= rw_d;
            l_q    <= l_d;
            u_q    <= u_d;
            err_q  <= err_d;
            ehi_q  <= ehi_d;
            act_q  <= act_d;
            berr_q <= berr_d;
            as_q   <= as_d;
            lds_q  <= lds_d;
            uds_q  <= uds_d;
            vma_q  <= vma_d;
            we_q   <= we_d;
            doe_q  <= doe_d;
            dle_q  <= dle_d;
`ifdef IOB_MASTER_TIMEOUT_EN
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign bus.IOACT   = act_q;
    assign bus.IOBERR  = berr_q;
    assign bus.nASout  = as_q;
    assign bus.nLDSout = lds_q;
    assign bus.nUDSout = uds_q;
    assign bus.nVMAout = vma_q;
    assign bus.nWEout  = we_q;
    assign bus.nDoutOE = doe_q;
    assign bus.nDinLE  = dle_q;
endmodule

// File: tb/tb_iob_master.sv
// tb_iob_master: randomized bus cycles scored against a transaction-level
// model of strobe timing, termination priority and reset behaviour.
module tb_iob_master;
    logic CLK;
    logic nRST;
    int   n_vec = 0;
    int   n_err = 0;
    int   ecnt;

    iob_master_if bus ();

    iob_master #(.TIMEOUT(10'd16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // E: period 10 CLK, changes away from both clock edges
    initial begin
        bus.E = 1'b0;
        ecnt  = 0;
        forever begin
            @(posedge CLK);
            #2;
            ecnt  = (ecnt == 9) ? 0 : ecnt + 1;
            bus.E = (ecnt >= 5);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    function automatic int pins();
        return int'({bus.nASout, bus.nLDSout, bus.nUDSout, bus.nVMAout,
                     bus.nWEout, bus.nDoutOE, bus.nDinLE,
                     bus.IOACT, bus.IOBERR});
    endfunction

    // kind: 0 DTACK, 1 BERR, 2 DTACK+BERR, 3 VPA, 4 no termination
    // d: cycles after nAS is first seen low before the termination asserts
    task automatic run_txn(input bit rw, input bit l, input bit u,
                           input int kind, input int d);
        int  cyc, as_at, lds_at, uds_at, vma_at, n_as, n_dle, efall;
        int  hold, seen_act, rel, exp_lds, exp_uds;
        bit  done, we_as, doe_as, e_prev, berr;
        berr   = (kind == 1) || (kind == 2);
        cyc    = 0;
        as_at  = -1;
        lds_at = -1;
        uds_at = -1;
        vma_at = -1;
        n_as   = 0;
        n_dle  = 0;
        efall  = 0;
        done   = 1'b0;
        we_as  = 1'b0;
        doe_as = 1'b0;
        rel    = 0;
        e_prev = bus.E;
        @(negedge CLK);
        bus.IOREQ = 1'b1;
        bus.IORW  = rw;
        bus.IOL   = l;
        bus.IOU   = u;
        while (!done && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            if (bus.IOACT) bus.IOREQ = 1'b0;
            if (!bus.nASout) begin
                if (as_at < 0) begin
                    as_at  = cyc;
                    we_as  = bus.nWEout;
                    doe_as = bus.nDoutOE;
                end
                n_as++;
                if (!bus.nLDSout && lds_at < 0) lds_at = cyc;
                if (!bus.nUDSout && uds_at < 0) uds_at = cyc;
                if (!bus.nVMAout && vma_at < 0) vma_at = cyc;
                if (!bus.nDinLE) n_dle++;
                if (!bus.nVMAout && e_prev && !bus.E) efall++;
                if (kind <= 3 && cyc - as_at == d) begin
                    if (kind == 0 || kind == 2) bus.nDTACK = 1'b0;
                    if (kind == 1 || kind == 2) bus.nBERR  = 1'b0;
                    if (kind == 3) bus.nVPA = 1'b0;
                end
            end else if (as_at >= 0) begin
                done = 1'b1;
                rel  = int'({bus.nLDSout, bus.nUDSout, bus.nVMAout,
                             bus.nDoutOE, bus.nDinLE, bus.IOACT,
                             bus.nWEout});
            end
            e_prev = bus.E;
        end
        check("txn_done", int'(done), 1);
        exp_lds = l ? as_at + (rw ? 0 : 1) : -1;
        exp_uds = u ? as_at + (rw ? 0 : 1) : -1;
        check("we_at_as", int'(we_as), int'(rw));
        check("doe_at_as", int'(doe_as), int'(rw));
        check("lds_timing", lds_at, exp_lds);
        check("uds_timing", uds_at, exp_uds);
        check("release", rel, int'({6'b111110, rw}));
        check("ioberr", int'(bus.IOBERR), int'(berr || kind == 4));
        check("dinle_pulses", n_dle, (rw && !berr && kind != 4) ? 1 : 0);
        if (kind <= 2)
            check("as_len", n_as, d + 4);
        else if (kind == 4)
            check("tmo_as_len", n_as, 17);
        if (kind == 3) begin
            check("vma_seen", int'(vma_at >= 0), 1);
            check("vma_efall", int'(efall >= 1), 1);
            check("vpa_len_bound", int'(n_as <= d + 30), 1);
        end else begin
            check("no_vma", vma_at, -1);
        end
        if (kind <= 3) begin
            // terminations still asserted: a new request must be ignored
            hold      = $urandom_range(1, 4);
            seen_act  = 0;
            bus.IOREQ = 1'b1;
            repeat (hold) begin
                @(negedge CLK);
                if (bus.IOACT) seen_act++;
            end
            bus.IOREQ  = 1'b0;
            bus.nDTACK = 1'b1;
            bus.nBERR  = 1'b1;
            bus.nVPA   = 1'b1;
            check("rec_hold", seen_act, 0);
            repeat (5) @(negedge CLK);
        end else begin
            repeat (3) @(negedge CLK);
        end
    endtask

    initial begin
        int cyc, lost, kind;
        nRST       = 1'b0;
        bus.IOREQ  = 1'b0;
        bus.IORW   = 1'b0;
        bus.IOL    = 1'b0;
        bus.IOU    = 1'b0;
        bus.nDTACK = 1'b1;
        bus.nVPA   = 1'b1;
        bus.nBERR  = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_pins", pins(), int'(9'b111111100));
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        run_txn(1'b1, 1'b1, 1'b1, 0, 3);
        run_txn(1'b0, 1'b1, 1'b0, 0, 2);
        run_txn(1'b1, 1'b1, 1'b1, 2, 1);
        run_txn(1'b0, 1'b0, 1'b1, 1, 0);
        run_txn(1'b1, 1'b0, 1'b0, 0, 4);
`ifdef IOB_MASTER_TIMEOUT_EN
        run_txn(1'b1, 1'b1, 1'b1, 4, 0);
        run_txn(1'b0, 1'b1, 1'b1, 4, 0);
`else
        run_txn(1'b1, 1'b1, 1'b1, 3, 2);
        run_txn(1'b0, 1'b1, 1'b1, 3, 0);
`endif
        for (int i = 0; i < 40; i++) begin
`ifdef IOB_MASTER_TIMEOUT_EN
            kind = $urandom_range(0, 2);
`else
            kind = $urandom_range(0, 3);
`endif
            run_txn(1'($urandom), 1'($urandom), 1'($urandom),
                    kind, $urandom_range(0, 5));
        end

        // unterminated cycle, then reset in the middle of S_WAIT
        @(negedge CLK);
        bus.IOREQ = 1'b1;
        bus.IORW  = 1'($urandom);
        bus.IOL   = 1'b1;
        bus.IOU   = 1'b1;
        cyc = 0;
        while (bus.nASout && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (bus.IOACT) bus.IOREQ = 1'b0;
        end
        check("hang_as_low", int'(bus.nASout), 0);
`ifndef IOB_MASTER_TIMEOUT_EN
        lost = 0;
        repeat (500) begin
            @(negedge CLK);
            if (!bus.IOACT || bus.nASout) lost++;
        end
        check("no_timeout", lost, 0);
`else
        lost = 0;
        repeat (3) @(negedge CLK);
`endif
        nRST = 1'b0;
        #1;
        check("async_reset", pins(), int'(9'b111111100));
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        run_txn(1'b1, 1'b1, 1'b1, 0, 2);
        run_txn(1'b0, 1'b1, 1'b1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
